// File: rtl/cpu_types_pkg.sv
// Shared datapath types plus the memory arbiter's state and grant encodings.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arb_state_t;

  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_request_arbiter_watchdog_counter.sv
// Grant watchdog: counts grant cycles without ramready and flags the last allowed cycle.
module watchdog_counter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_request_arbiter.sv
// Shares the single RAM port between instruction fetch and data access with
// round-robin arbitration, halt gating of fetches and a watchdog abort.
module mem_request_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  iREN,
  input  word_t iaddr,
  input  logic  dREN,
  input  logic  dWEN,
  input  word_t daddr,
  input  word_t dstore,
  input  logic  halt,
  input  word_t ramload,
  input  logic  ramready,
  output logic  ihit,
  output logic  dhit,
  output word_t iload,
  output word_t dload,
  output logic  ramREN,
  output logic  ramWEN,
  output word_t ramaddr,
  output word_t ramstore,
  output logic  err
);

  arb_state_t state_q, state_d;
  grant_t     last_q, last_d;
  logic       err_q, err_d;
  logic       d_req;
  logic       expired;

  assign d_req = dREN | dWEN;

  // Counter is held clear while idle, so it starts at zero on every grant entry.
  watchdog_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk_i    (CLK),
    .rst_i    (RST),
    .clear_i  (state_q == IDLE),
    .enable_i ((state_q != IDLE) && !ramready),
    .expired_o(expired)
  );

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    err_d    = err_q;
    ihit     = 1'b0;
    dhit     = 1'b0;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    unique case (state_q)
      IDLE: begin
        if (d_req && (!iREN || halt || last_q == INSTR)) begin
          state_d = DGNT;
        end else if (iREN && !halt) begin
          state_d = IGNT;
        end
      end
      IGNT: begin
        ramaddr = iaddr;
        if (!iREN) begin
          state_d = IDLE;
        end else begin
          ramREN = 1'b1;
          if (ramready) begin
            ihit    = 1'b1;
            iload   = ramload;
            last_d  = INSTR;
            state_d = IDLE;
          end else if (expired) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      DGNT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        if (!d_req) begin
          state_d = IDLE;
        end else begin
          ramWEN = dWEN;
          ramREN = dREN & ~dWEN;
          if (ramready) begin
            dhit    = 1'b1;
            dload   = dWEN ? '0 : ramload;
            last_d  = DATA;
            state_d = IDLE;
          end else if (expired) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      last_q  <= INSTR;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Self-checking bench for mem_request_arbiter: directed scenarios plus random
// traffic compared against a transaction-level reference model.
module tb_mem_request_arbiter;

  localparam int unsigned TIMEOUT = 16;

  logic        CLK = 1'b0;
  logic        RST, iREN, dREN, dWEN, halt, ramready;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic        ihit, dhit, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the port (0 none, 1 fetch, 2 data), cycles waited,
  // who was served last (1 fetch, 2 data), and the sticky error.
  int   m_owner;
  int   m_wait;
  int   m_last;
  logic m_err;

  logic        s_ihit, s_dhit, s_ren, s_wen, s_err;
  logic [31:0] s_iload, s_dload, s_addr, s_store;

  mem_request_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .halt(halt), .ramload(ramload),
    .ramready(ramready), .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0;
    m_wait  = 0;
    m_last  = 1;
    m_err   = 1'b0;
  endtask

  // Called at a negedge with inputs already driven; checks one cycle, ends at next negedge.
  task automatic step();
    logic [31:0] e_addr, e_store, e_iload, e_dload;
    logic        e_ren, e_wen, e_ihit, e_dhit, active;
    #1;
    e_addr = '0; e_store = '0; e_iload = '0; e_dload = '0;
    e_ren = 1'b0; e_wen = 1'b0; e_ihit = 1'b0; e_dhit = 1'b0;
    active = (m_owner == 1) ? iREN : (m_owner == 2) ? (dREN | dWEN) : 1'b0;
    if (m_owner == 1) begin
      e_addr = iaddr;
      e_ren  = iREN;
      if (active && ramready) begin e_ihit = 1'b1; e_iload = ramload; end
    end else if (m_owner == 2) begin
      e_addr  = daddr;
      e_store = dstore;
      if (active) begin
        e_wen = dWEN;
        e_ren = dREN && !dWEN;
        if (ramready) begin e_dhit = 1'b1; e_dload = dWEN ? 32'h0 : ramload; end
      end
    end
    check("ihit", 32'(ihit), 32'(e_ihit));
    check("dhit", 32'(dhit), 32'(e_dhit));
    check("iload", iload, e_iload);
    check("dload", dload, e_dload);
    check("ramREN", 32'(ramREN), 32'(e_ren));
    check("ramWEN", 32'(ramWEN), 32'(e_wen));
    check("ramaddr", ramaddr, e_addr);
    check("ramstore", ramstore, e_store);
    check("err", 32'(err), 32'(m_err));
    s_ihit = ihit; s_dhit = dhit; s_ren = ramREN; s_wen = ramWEN; s_err = err;
    s_iload = iload; s_dload = dload; s_addr = ramaddr; s_store = ramstore;
    @(posedge CLK);
    if (RST) begin
      model_reset();
    end else if (m_owner == 0) begin
      m_wait = 0;
      if ((dREN || dWEN) && (!iREN || halt || m_last == 1)) m_owner = 2;
      else if (iREN && !halt) m_owner = 1;
    end else if (!active) begin
      m_owner = 0;
    end else if (ramready) begin
      m_last  = m_owner;
      m_owner = 0;
    end else if (m_wait == TIMEOUT - 1) begin
      m_err   = 1'b1;
      m_owner = 0;
    end else begin
      m_wait++;
    end
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    RST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; halt = 1'b0; ramready = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST = 1'b1;
    @(posedge CLK);
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    int seq;
    int cnt;
    int rr_mode;
    idle_inputs();
    RST = 1'b1;
    @(negedge CLK);
    do_reset();

    // Reset state: everything quiet.
    step();
    check("rst_outputs", {s_ihit, s_dhit, s_ren, s_wen, s_err}, 32'h0);

    // Single fetch, ramready in the second grant cycle.
    iREN = 1'b1; iaddr = 32'h0000_0040; ramload = 32'h2408_0005;
    step();
    step();
    check("fetch_ren", 32'(s_ren), 32'h1);
    check("fetch_addr", s_addr, 32'h40);
    ramready = 1'b1;
    step();
    check("fetch_ihit", 32'(s_ihit), 32'h1);
    check("fetch_iload", s_iload, 32'h2408_0005);
    iREN = 1'b0; ramready = 1'b0;
    step();
    check("fetch_idle_after", 32'(s_ren), 32'h0);

    // Simultaneous requests alternate D, I, D, I after reset.
    do_reset();
    iREN = 1'b1; dREN = 1'b1; daddr = 32'h100; iaddr = 32'h44; ramready = 1'b1;
    seq = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (s_dhit) seq = seq * 4 + 2;
      else if (s_ihit) seq = seq * 4 + 1;
    end
    check("rr_order", 32'(seq), 32'd153);

    // Write and read asserted together: write wins.
    do_reset();
    dWEN = 1'b1; dREN = 1'b1; daddr = 32'h200; dstore = 32'hDEAD_BEEF;
    ramload = 32'h1234_5678; ramready = 1'b1;
    step();
    step();
    check("wr_wen", 32'(s_wen), 32'h1);
    check("wr_ren", 32'(s_ren), 32'h0);
    check("wr_store", s_store, 32'hDEAD_BEEF);
    check("wr_dhit", 32'(s_dhit), 32'h1);
    check("wr_dload", s_dload, 32'h0);

    // halt blocks fetch grants but data still goes through.
    do_reset();
    halt = 1'b1; iREN = 1'b1; ramready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (s_ren || s_ihit) cnt++;
    end
    check("halt_no_fetch", 32'(cnt), 32'h0);
    dREN = 1'b1; daddr = 32'h300;
    step();
    step();
    check("halt_dhit", 32'(s_dhit), 32'h1);

    // Watchdog: 16 grant cycles with no ramready, then abort with err.
    do_reset();
    dREN = 1'b1; daddr = 32'h400;
    step();
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (s_dhit) cnt++;
      if (!s_ren) cnt += 100;
    end
    check("wd_grant_cycles", 32'(cnt), 32'h0);
    dREN = 1'b0;
    step();
    check("wd_err", 32'(s_err), 32'h1);
    check("wd_idle", 32'(s_ren), 32'h0);
    iREN = 1'b1; ramready = 1'b1;
    step();
    step();
    check("wd_retry_ihit", 32'(s_ihit), 32'h1);
    check("wd_err_sticky", 32'(s_err), 32'h1);

    // Reset in the 3rd grant cycle abandons the fetch.
    do_reset();
    iREN = 1'b1; iaddr = 32'h80;
    step();
    step();
    step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    step();
    check("rstmid_ren", 32'(s_ren), 32'h0);
    check("rstmid_ihit", 32'(s_ihit), 32'h0);
    check("rstmid_err", 32'(s_err), 32'h0);

    // Random traffic, with stretches where RAM never answers.
    do_reset();
    rr_mode = 0;
    for (int i = 0; i < 2500; i++) begin
      if (i % 64 == 0) rr_mode = $urandom_range(0, 3);
      RST      = ($urandom_range(0, 299) == 0);
      iREN     = ($urandom_range(0, 3) != 0);
      dREN     = ($urandom_range(0, 2) == 0);
      dWEN     = ($urandom_range(0, 3) == 0);
      halt     = (rr_mode == 3) ? ($urandom_range(0, 1) == 1) : 1'b0;
      ramready = (rr_mode == 0) ? 1'b0 : ($urandom_range(0, 2) == 0);
      iaddr    = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
